// File: rtl/regfile_sb.sv
// regfile_sb: dual-write register file with a per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding of data and busy.
module regfile_sb #(
  parameter int width     = 64,
  parameter int addr_bits = 5,
  parameter int pend_bits = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [addr_bits-1:0] A_addr,
  input  logic [addr_bits-1:0] B_addr,
  output logic [width-1:0]     A_data,
  output logic [width-1:0]     B_data,
  output logic                 A_busy,
  output logic                 B_busy,
  input  logic [addr_bits-1:0] W0_addr,
  input  logic [width-1:0]     W0_data,
  input  logic                 W0_enable,
  input  logic [addr_bits-1:0] W1_addr,
  input  logic [width-1:0]     W1_data,
  input  logic                 W1_enable,
  input  logic [addr_bits-1:0] issue_addr,
  input  logic                 issue_enable,
  output logic                 issue_ok
);
  localparam int depth = 2 ** addr_bits;
  localparam logic [pend_bits-1:0] cnt_max = '1;

  logic [width-1:0]     regs_q [depth];
  logic [width-1:0]     regs_d [depth];
  logic [pend_bits-1:0] cnt_q  [depth];
  logic [pend_bits-1:0] cnt_d  [depth];

  // Net of one optional issue and up to two retirements, floored at zero.
  function automatic logic [pend_bits-1:0] next_cnt(input logic [pend_bits-1:0] c,
                                                    input logic inc, input logic d0,
                                                    input logic d1);
    logic [pend_bits+1:0] s;
    logic [pend_bits+1:0] d;
    s = (pend_bits+2)'(c) + (pend_bits+2)'(inc);
    d = (pend_bits+2)'(d0) + (pend_bits+2)'(d1);
    return s >= d ? pend_bits'(s - d) : '0;
  endfunction

  assign issue_ok = issue_enable && issue_addr != '0 && cnt_q[issue_addr] != cnt_max;

  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    for (int i = 1; i < depth; i++) begin
      regs_d[i] = (W1_enable && W1_addr == addr_bits'(i)) ? W1_data :
                  (W0_enable && W0_addr == addr_bits'(i)) ? W0_data : regs_q[i];
      cnt_d[i]  = next_cnt(cnt_q[i], issue_ok && issue_addr == addr_bits'(i),
                           W0_enable && W0_addr == addr_bits'(i),
                           W1_enable && W1_addr == addr_bits'(i));
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic a_w0, a_w1, b_w0, b_w1;
  always_comb begin
    a_w0   = W0_enable && W0_addr == A_addr && A_addr != '0;
    a_w1   = W1_enable && W1_addr == A_addr && A_addr != '0;
    b_w0   = W0_enable && W0_addr == B_addr && B_addr != '0;
    b_w1   = W1_enable && W1_addr == B_addr && B_addr != '0;
    A_data = a_w1 ? W1_data : a_w0 ? W0_data : regs_q[A_addr];
    B_data = b_w1 ? W1_data : b_w0 ? W0_data : regs_q[B_addr];
    A_busy = A_addr != '0 && next_cnt(cnt_q[A_addr], 1'b0, a_w0, a_w1) != '0;
    B_busy = B_addr != '0 && next_cnt(cnt_q[B_addr], 1'b0, b_w0, b_w1) != '0;
  end
`else
  always_comb begin
    A_data = regs_q[A_addr];
    B_data = regs_q[B_addr];
    A_busy = A_addr != '0 && cnt_q[A_addr] != '0;
    B_busy = B_addr != '0 && cnt_q[B_addr] != '0;
  end
`endif

  // Entry 0 is never written after reset, so it reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of the default regfile_sb plus a 32-bit, 8-entry instance.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  A_addr = '0, B_addr = '0, W0_addr = '0, W1_addr = '0, issue_addr = '0;
  logic [63:0] A_data, B_data, W0_data = '0, W1_data = '0;
  logic        A_busy, B_busy, issue_ok;
  logic        W0_enable = 1'b0, W1_enable = 1'b0, issue_enable = 1'b0;

  logic [2:0]  n_A_addr = '0, n_B_addr = '0, n_W0_addr = '0, n_W1_addr = '0, n_issue_addr = '0;
  logic [31:0] n_A_data, n_B_data, n_W0_data = '0, n_W1_data = '0;
  logic        n_A_busy, n_B_busy, n_issue_ok;
  logic        n_W0_enable = 1'b0, n_W1_enable = 1'b0, n_issue_enable = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .reset(reset),
    .A_addr(A_addr), .B_addr(B_addr), .A_data(A_data), .B_data(B_data),
    .A_busy(A_busy), .B_busy(B_busy),
    .W0_addr(W0_addr), .W0_data(W0_data), .W0_enable(W0_enable),
    .W1_addr(W1_addr), .W1_data(W1_data), .W1_enable(W1_enable),
    .issue_addr(issue_addr), .issue_enable(issue_enable), .issue_ok(issue_ok)
  );

  regfile_sb #(.width(32), .addr_bits(3)) dut_n (
    .clk(clk), .reset(reset),
    .A_addr(n_A_addr), .B_addr(n_B_addr), .A_data(n_A_data), .B_data(n_B_data),
    .A_busy(n_A_busy), .B_busy(n_B_busy),
    .W0_addr(n_W0_addr), .W0_data(n_W0_data), .W0_enable(n_W0_enable),
    .W1_addr(n_W1_addr), .W1_data(n_W1_data), .W1_enable(n_W1_enable),
    .issue_addr(n_issue_addr), .issue_enable(n_issue_enable), .issue_ok(n_issue_ok)
  );

  task automatic step();
    @(posedge clk);
    #1;
    W0_enable = 1'b0; W1_enable = 1'b0; issue_enable = 1'b0;
    n_W0_enable = 1'b0; n_W1_enable = 1'b0; n_issue_enable = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    A_addr = 5'd5; B_addr = 5'd9; issue_addr = 5'd5; issue_enable = 1'b1; n_A_addr = 3'd7;
    #2;
    checks++; if (A_data !== 64'h0) begin errors++; $display("FAIL reset_a_data: got %h want 0", A_data); end
    checks++; if (B_busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy: got %b want 0", B_busy); end
    checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL reset_issue_ok: got %b want 1", issue_ok); end
    checks++; if (n_A_data !== 32'h0) begin errors++; $display("FAIL reset_n_a_data: got %h want 0", n_A_data); end
    issue_enable = 1'b0;
    #10 reset = 1'b0;
    #1;
    for (int i = 1; i < 32; i++) begin
      W0_addr = 5'(i); W0_data = 64'hdeadbeef; W0_enable = 1'b1;
      step();
    end
    issue_addr = 5'd9; issue_enable = 1'b1;
    step();
    A_addr = 5'd31; B_addr = 5'd9; #1;
    checks++; if (A_data !== 64'hdeadbeef) begin errors++; $display("FAIL prefill_a: got %h want deadbeef", A_data); end
    checks++; if (B_data !== 64'hdeadbeef) begin errors++; $display("FAIL prefill_b: got %h want deadbeef", B_data); end
    checks++; if (B_busy !== 1'b1) begin errors++; $display("FAIL prefill_busy: got %b want 1", B_busy); end
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      A_addr = 5'(i); B_addr = 5'(31 - i); #1;
      checks++; if (A_data !== 64'h0 || B_data !== 64'h0) begin errors++; $display("FAIL reset_clear_data[%0d]: got %h/%h want 0/0", i, A_data, B_data); end
      checks++; if (A_busy !== 1'b0 || B_busy !== 1'b0) begin errors++; $display("FAIL reset_clear_busy[%0d]: got %b/%b want 0/0", i, A_busy, B_busy); end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    W0_addr = 5'd0; W0_data = 64'hdeadbeef; W0_enable = 1'b1;
    step();
    A_addr = 5'd0; B_addr = 5'd31; #1;
    checks++; if (A_data !== 64'h0) begin errors++; $display("FAIL write_r0: got %h want 0", A_data); end
    checks++; if (A_busy !== 1'b0) begin errors++; $display("FAIL write_r0_busy: got %b want 0", A_busy); end
    checks++; if (B_data !== 64'h0) begin errors++; $display("FAIL reset_persist: got %h want 0", B_data); end
  endtask

  task automatic test_dual_write();
    W0_addr = 5'h15; W0_data = 64'hcafebabe; W0_enable = 1'b1;
    W1_addr = 5'h15; W1_data = 64'h1234;     W1_enable = 1'b1;
    step();
    A_addr = 5'h15; #1;
    checks++; if (A_data !== 64'h1234) begin errors++; $display("FAIL dual_write: got %h want 1234", A_data); end
    W0_data = 64'hffff; W0_enable = 1'b0;
    step();
    checks++; if (A_data !== 64'h1234) begin errors++; $display("FAIL disabled_write: got %h want 1234", A_data); end
  endtask

  task automatic test_saturation();
    B_addr = 5'h14;
    for (int k = 0; k < 4; k++) begin
      issue_addr = 5'h14; issue_enable = 1'b1; #1;
      checks++; if (issue_ok !== (k < 3)) begin errors++; $display("FAIL sat_issue_ok[%0d]: got %b want %b", k, issue_ok, k < 3); end
      step();
    end
    checks++; if (B_busy !== 1'b1) begin errors++; $display("FAIL sat_busy: got %b want 1", B_busy); end
    for (int k = 0; k < 4; k++) begin
      W0_addr = 5'h14; W0_data = 64'(k); W0_enable = 1'b1;
      step();
      checks++; if (B_busy !== (k < 2)) begin errors++; $display("FAIL sat_drain[%0d]: got %b want %b", k, B_busy, k < 2); end
    end
    issue_addr = 5'h14; issue_enable = 1'b1; #1;
    checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL sat_no_underflow: got %b want 1", issue_ok); end
    step();
    checks++; if (B_busy !== 1'b1) begin errors++; $display("FAIL sat_reissue: got %b want 1", B_busy); end
    W0_addr = 5'h14; W0_enable = 1'b1;
    step();
    checks++; if (B_busy !== 1'b0) begin errors++; $display("FAIL sat_reretire: got %b want 0", B_busy); end
  endtask

  task automatic test_simultaneous();
    A_addr = 5'h08;
    issue_addr = 5'h08; issue_enable = 1'b1;
    step();
    checks++; if (A_busy !== 1'b1) begin errors++; $display("FAIL sim_setup: got %b want 1", A_busy); end
    issue_addr = 5'h08; issue_enable = 1'b1;
    W0_addr = 5'h08; W0_data = 64'h11; W0_enable = 1'b1;
    W1_addr = 5'h08; W1_data = 64'h22; W1_enable = 1'b1;
    #1;
    checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL sim_issue_ok: got %b want 1", issue_ok); end
    step();
    checks++; if (A_busy !== 1'b0) begin errors++; $display("FAIL sim_triple_busy: got %b want 0", A_busy); end
    checks++; if (A_data !== 64'h22) begin errors++; $display("FAIL sim_triple_data: got %h want 22", A_data); end
    issue_addr = 5'h08; issue_enable = 1'b1;
    step();
    issue_addr = 5'h08; issue_enable = 1'b1;
    W0_addr = 5'h08; W0_data = 64'h33; W0_enable = 1'b1;
    step();
    checks++; if (A_busy !== 1'b1) begin errors++; $display("FAIL sim_net_zero: got %b want 1", A_busy); end
    W0_addr = 5'h08; W0_enable = 1'b1;
    step();
    checks++; if (A_busy !== 1'b0) begin errors++; $display("FAIL sim_final: got %b want 0", A_busy); end
  endtask

  task automatic test_issue_r0();
    issue_addr = 5'd0; issue_enable = 1'b1; #1;
    checks++; if (issue_ok !== 1'b0) begin errors++; $display("FAIL issue_r0_ok: got %b want 0", issue_ok); end
    step();
    A_addr = 5'd0; #1;
    checks++; if (A_busy !== 1'b0) begin errors++; $display("FAIL issue_r0_busy: got %b want 0", A_busy); end
  endtask

  task automatic test_bypass();
    W0_addr = 5'h03; W0_data = 64'h5555; W0_enable = 1'b1;
    step();
    issue_addr = 5'h03; issue_enable = 1'b1;
    step();
    A_addr = 5'h03;
    W0_addr = 5'h03; W0_data = 64'hbbbb; W0_enable = 1'b1;
    W1_addr = 5'h03; W1_data = 64'haaaa; W1_enable = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (A_data !== 64'haaaa) begin errors++; $display("FAIL bypass_pre_data: got %h want aaaa", A_data); end
    checks++; if (A_busy !== 1'b0) begin errors++; $display("FAIL bypass_pre_busy: got %b want 0", A_busy); end
`else
    checks++; if (A_data !== 64'h5555) begin errors++; $display("FAIL bypass_pre_data: got %h want 5555", A_data); end
    checks++; if (A_busy !== 1'b1) begin errors++; $display("FAIL bypass_pre_busy: got %b want 1", A_busy); end
`endif
    step();
    checks++; if (A_data !== 64'haaaa) begin errors++; $display("FAIL bypass_post_data: got %h want aaaa", A_data); end
    checks++; if (A_busy !== 1'b0) begin errors++; $display("FAIL bypass_post_busy: got %b want 0", A_busy); end
  endtask

  task automatic test_width();
    n_W0_addr = 3'd7; n_W0_data = 32'hffffffff; n_W0_enable = 1'b1;
    n_W1_addr = 3'd5; n_W1_data = 32'h12345678; n_W1_enable = 1'b1;
    step();
    n_A_addr = 3'd7; n_B_addr = 3'd5; #1;
    checks++; if (n_A_data !== 32'hffffffff) begin errors++; $display("FAIL width_r7: got %h want ffffffff", n_A_data); end
    checks++; if (n_B_data !== 32'h12345678) begin errors++; $display("FAIL width_r5: got %h want 12345678", n_B_data); end
    n_W1_addr = 3'd0; n_W1_data = 32'hffffffff; n_W1_enable = 1'b1;
    n_issue_addr = 3'd7; n_issue_enable = 1'b1;
    step();
    n_A_addr = 3'd0; #1;
    checks++; if (n_A_data !== 32'h0) begin errors++; $display("FAIL width_r0: got %h want 0", n_A_data); end
    checks++; if (n_B_busy !== 1'b0) begin errors++; $display("FAIL width_r5_busy: got %b want 0", n_B_busy); end
    n_B_addr = 3'd7; #1;
    checks++; if (n_B_busy !== 1'b1) begin errors++; $display("FAIL width_r7_busy: got %b want 1", n_B_busy); end
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_saturation();
    test_simultaneous();
    test_issue_r0();
    test_bypass();
    test_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-write-port register file for the 0dMIPS core.
- Provides two combinational read ports and two clocked write ports (W0 older, W1 younger). Register 0 is hardwired to zero.
- Adds a per-register pending-write scoreboard. Decode increments a register's counter at issue; writeback decrements it. Per-port busy flags drive hazard stalls.
- Sits between decode (read/issue) and writeback (write/retire) in a dual-issue pipeline.

Parameters:
- width, 64, data width of each register in bits.
- addr_bits, 5, register address width; depth is 2**addr_bits.
- pend_bits, 2, width of each per-register pending counter; maximum count is 2**pend_bits-1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- A_addr  input  addr_bits  read port A address.
- B_addr  input  addr_bits  read port B address.
- A_data  output  width  register contents at A_addr.
- B_data  output  width  register contents at B_addr.
- A_busy  output  1  register at A_addr has pending writes.
- B_busy  output  1  register at B_addr has pending writes.
- W0_addr  input  addr_bits  write port 0 address (older).
- W0_data  input  width  write port 0 data.
- W0_enable  input  1  write port 0 enable; also retires one pending write.
- W1_addr  input  addr_bits  write port 1 address (younger).
- W1_data  input  width  write port 1 data.
- W1_enable  input  1  write port 1 enable; also retires one pending write.
- issue_addr  input  addr_bits  destination register of the instruction being issued.
- issue_enable  input  1  request to record a pending write.
- issue_ok  output  1  combinational; issue accepted this cycle.

Behaviour:
- Clocking and reset:
  - Single clock clk. Reset is asynchronous and active-high, named reset.
  - While reset is high, every register and every pending counter is 0. Consequently A_data=B_data=0, A_busy=B_busy=0, and issue_ok=1 whenever issue_enable=1 and issue_addr is not 0.
  - Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Reads:
  - Combinational; zero latency.
  - Address 0 always returns 0.
- Writes:
  - Take effect on the rising edge when the enable is high; visible on the read ports after that edge.
  - A write to address 0 is discarded and does not touch any counter.
  - If W0 and W1 target the same non-zero address, W1_data is stored.
- Pending counters (per register, pend_bits wide; next value computed from all events in the cycle):
  - +1 if issue_enable and issue_ok and issue_addr==r.
  - -1 for each write port enabled with W*_addr==r.
  - The result saturates at 0; there is no underflow, so a stray writeback to an idle register leaves 0.
  - Issue and writeback to the same register in one cycle: net change is +1-1=0, or +1-2=-1 when both write ports target it.
  - issue_ok = issue_enable and issue_addr!=0 and count[issue_addr] < 2**pend_bits-1.
  - Full counter: issue_ok=0 and the count is unchanged. Rejection is not relieved by a same-cycle writeback; the issuer retries the next cycle.
  - Issue to address 0: issue_ok=0 and no state change; decode treats r0 destinations as no-issue.
- Busy flags:
  - A_busy = (count[A_addr]!=0), combinational, 0 for address 0. B_busy likewise.
  - Without the optional feature, busy and data reflect state before the current edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding. If an enabled write port targets a non-zero A_addr or B_addr, that port's data appears on the read port in the same cycle; W1 wins over W0.
  - Busy is computed on the post-writeback count: count minus the same-cycle writes to that address, floored at 0. A count of 1 being written this cycle reads not-busy.
- Undefined:
  - Reads return only stored values.
  - Busy uses the stored count.
  - Same-cycle write data is visible only after the edge.

Test Plan:
- Reset:
  - Stimulus: write 0xdeadbeef to every address, then pulse reset between clock edges.
  - Response: all reads return 0 and all busy flags are 0 immediately; W0 write to address 0 with 0xdeadbeef keeps A_data(0)=0.
- Dual-write conflict:
  - Stimulus: W0=(0x15,0xcafebabe) and W1=(0x15,0x1234) in one cycle.
  - Response: A_data(0x15)=0x1234 after the edge. A following W0-only write of 0xffff with W0_enable=0 leaves 0x1234.
- Scoreboard saturation (pend_bits=2):
  - Stimulus: issue 0x14 on four consecutive cycles.
  - Response: issue_ok = 1,1,1,0; count=3; B_busy(0x14)=1. Three W0 writes to 0x14 then give B_busy=0; a fourth write leaves count 0.
- Simultaneous events:
  - Stimulus: count(0x08)=1; same cycle issue 0x08 plus W0 and W1 both writing 0x08.
  - Response: count becomes 0 and A_busy=0. With count=1, issue plus a single W0 write leaves count=1.
- Bypass:
  - Stimulus: W1=(0x03,0xaaaa), A_addr=0x03, count(0x03)=1.
  - Response with REGFILE_BYPASS_EN: A_data=0xaaaa and A_busy=0 before the edge.
  - Response without it: old value and A_busy=1 before the edge; 0xaaaa and A_busy=0 after the edge.
- Width generality:
  - Stimulus: instantiate width=32, addr_bits=3.
  - Response: 8 registers; a write of 0xffffffff reads back intact; address 7 works and address 0 stays zero.
